// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM state type
// and the byte/halfword lane helpers used by lsu_align.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MERGE,
    ST_WRITE,
    ST_RESP
  } lsu_state_t;

  // Pull the addressed lane out of a memory word and extend it to 32 bits.
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [2:0]  f3);
    logic [31:0] bsh;
    logic [31:0] hsh;
    logic [31:0] res;
    bsh = word >> {off, 3'b000};
    hsh = word >> {off[1], 4'b0000};
    case (f3)
      F3_B:    res = {{24{bsh[7]}}, bsh[7:0]};
      F3_BU:   res = {24'h000000, bsh[7:0]};
      F3_H:    res = {{16{hsh[15]}}, hsh[15:0]};
      F3_HU:   res = {16'h0000, hsh[15:0]};
      default: res = word;
    endcase
    return res;
  endfunction

  // Replace the addressed lane of a memory word with right-aligned store data.
  function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                             input logic [1:0]  off,
                                             input logic [2:0]  f3,
                                             input logic [31:0] wdata);
    logic [31:0] mask;
    logic [31:0] data;
    case (f3)
      F3_B: begin
        mask = 32'h0000_00FF << {off, 3'b000};
        data = {24'h000000, wdata[7:0]} << {off, 3'b000};
      end
      F3_H: begin
        mask = 32'h0000_FFFF << {off[1], 4'b0000};
        data = {16'h0000, wdata[15:0]} << {off[1], 4'b0000};
      end
      default: begin
        mask = '1;
        data = wdata;
      end
    endcase
    return (word & ~mask) | (data & mask);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane datapath: load extract/extend and store lane merge.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] mem_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  always_comb begin
    load_data   = lane_extract(mem_word, offset, funct3);
    merged_word = lane_merge(mem_word, offset, funct3, wdata);
  end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit in front of a word-wide memory without byte enables;
// sub-word stores are done as read-modify-write.
module lsu_rmw
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 8192
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_read_en,
  output logic        mem_write_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  lsu_state_t  state;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;
  logic        bad_f3;
  logic        misaligned;
  logic        out_of_range;
  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] merged_word;

  always_comb begin
    bad_f3     = 1'b0;
    misaligned = 1'b0;
    case (req_funct3)
      F3_B:    bad_f3 = 1'b0;
      F3_H:    misaligned = req_addr[0];
      F3_W:    misaligned = |req_addr[1:0];
      F3_BU:   bad_f3 = req_we;
      F3_HU: begin
        bad_f3     = req_we;
        misaligned = req_addr[0];
      end
      default: bad_f3 = 1'b1;
    endcase
    out_of_range = {2'b00, req_addr[31:2]} >= 32'(MEM_WORDS);
    req_err      = bad_f3 | misaligned | out_of_range;
  end

  lsu_align u_align (
    .funct3      (f3_q),
    .offset      (off_q),
    .mem_word    (mem_read_data),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  // Memory enables are registered alongside the state transition so they
  // reflect the current state only and clear asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      req_ready      <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      rsp_err        <= 1'b0;
      mem_read_en    <= 1'b0;
      mem_write_en   <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      f3_q           <= '0;
      off_q          <= '0;
      wdata_q        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            f3_q      <= req_funct3;
            off_q     <= req_addr[1:0];
            wdata_q   <= req_wdata;
            rsp_rdata <= '0;
            rsp_err   <= req_err;
            if (req_err) begin
              rsp_valid <= 1'b1;
              state     <= ST_RESP;
            end else begin
              mem_addr <= {req_addr[31:2], 2'b00};
              if (!req_we) begin
                mem_read_en <= 1'b1;
                state       <= ST_LOAD;
              end else if (req_funct3 == F3_W) begin
                mem_write_en   <= 1'b1;
                mem_write_data <= req_wdata;
                state          <= ST_WRITE;
              end else begin
                mem_read_en <= 1'b1;
                state       <= ST_MERGE;
              end
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        ST_LOAD: begin
          mem_read_en <= 1'b0;
          rsp_rdata   <= load_data;
          rsp_valid   <= 1'b1;
          state       <= ST_RESP;
        end
        ST_MERGE: begin
          mem_read_en    <= 1'b0;
          mem_write_en   <= 1'b1;
          mem_write_data <= merged_word;
          state          <= ST_WRITE;
        end
        ST_WRITE: begin
          mem_write_en <= 1'b0;
          rsp_valid    <= 1'b1;
          state        <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          mem_read_en  <= 1'b0;
          mem_write_en <= 1'b0;
          rsp_valid    <= 1'b0;
          state        <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_rmw.sv
// Directed bench for lsu_rmw with a behavioural word memory behind it.
module tb_lsu_rmw;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  logic [31:0] mem [0:8191];
  logic        pre_we = 1'b0;
  logic [12:0] pre_idx = '0;
  logic [31:0] pre_data = '0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_addr[14:2]];

  always @(posedge clk) begin
    if (mem_write_en)
      mem[mem_addr[14:2]] <= mem_write_data;
    else if (pre_we)
      mem[pre_idx] <= pre_data;
  end

  lsu_rmw #(.MEM_WORDS(8192)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .mem_read_en    (mem_read_en),
    .mem_write_en   (mem_write_en),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  task automatic preload(input logic [12:0] idx, input logic [31:0] data);
    @(negedge clk);
    pre_idx  = idx;
    pre_data = data;
    pre_we   = 1'b1;
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  // Issues one request and completes it; lat is the cycle (relative to the
  // accept edge) at which rsp_valid was first sampled high, 0 on timeout.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic early_ready,
                        output int lat, output logic [31:0] rdata, output logic err,
                        output int rd_cnt, output int wr_cnt, output int wr_at);
    lat = 0; rdata = '0; err = 1'b0; rd_cnt = 0; wr_cnt = 0; wr_at = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    rsp_ready = early_ready;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (mem_read_en) rd_cnt++;
      if (mem_write_en) begin
        wr_cnt++;
        wr_at = k;
      end
      if (rsp_valid) begin
        lat = k; rdata = rsp_rdata; err = rsp_err;
        break;
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if ({req_ready, rsp_valid, rsp_err, mem_read_en, mem_write_en} !== 5'b0 ||
        rsp_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_write_data !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got rdy=%b v=%b e=%b re=%b we=%b rd=%h a=%h wd=%h want all zero",
               req_ready, rsp_valid, rsp_err, mem_read_en, mem_write_en, rsp_rdata, mem_addr, mem_write_data);
    end
    preload(13'd4, 32'h8070_F0A1);
    preload(13'd8, 32'hA5A5_0008);
    preload(13'd8191, 32'h1357_9BDF);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: got rdy=%b v=%b want rdy=1 v=0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_loads();
    logic [31:0] addrs [5] = '{32'h13, 32'h13, 32'h12, 32'h10, 32'h7FFC};
    logic [2:0]  f3s   [5] = '{F3_B, F3_BU, F3_H, F3_HU, F3_W};
    logic [31:0] exps  [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8070, 32'h0000_F0A1, 32'h1357_9BDF};
    int lat, rc, wc, wa;
    logic [31:0] rd;
    logic er;
    for (int i = 0; i < 5; i++) begin
      do_req(1'b0, f3s[i], addrs[i], 32'h0, 1'b0, lat, rd, er, rc, wc, wa);
      vectors++;
      if (rd !== exps[i] || er !== 1'b0 || lat != 2 || wc != 0) begin
        miscompares++;
        $display("FAIL load_%0d: got data=%h err=%b lat=%0d wr=%0d want data=%h err=0 lat=2 wr=0",
                 i, rd, er, lat, wc, exps[i]);
      end
    end
  endtask

  task automatic test_stores();
    int lat, rc, wc, wa;
    logic [31:0] rd;
    logic er;
    do_req(1'b1, F3_B, 32'h11, 32'h0000_0055, 1'b0, lat, rd, er, rc, wc, wa);
    vectors++;
    if (lat != 3 || wc != 1 || wa != 2 || rd !== 32'h0 || er !== 1'b0) begin
      miscompares++;
      $display("FAIL sb_timing: got lat=%0d wr=%0d wr_at=%0d data=%h err=%b want lat=3 wr=1 wr_at=2 data=0 err=0",
               lat, wc, wa, rd, er);
    end
    do_req(1'b0, F3_W, 32'h10, 32'h0, 1'b0, lat, rd, er, rc, wc, wa);
    vectors++;
    if (rd !== 32'h8070_55A1 || lat != 2) begin
      miscompares++;
      $display("FAIL sb_readback: got %h lat=%0d want 807055a1 lat=2", rd, lat);
    end
    do_req(1'b1, F3_H, 32'h12, 32'h0000_BEEF, 1'b0, lat, rd, er, rc, wc, wa);
    vectors++;
    if (lat != 3 || wc != 1 || wa != 2) begin
      miscompares++;
      $display("FAIL sh_timing: got lat=%0d wr=%0d wr_at=%0d want lat=3 wr=1 wr_at=2", lat, wc, wa);
    end
    do_req(1'b1, F3_W, 32'h14, 32'hDEAD_BEEF, 1'b0, lat, rd, er, rc, wc, wa);
    vectors++;
    if (lat != 2 || wc != 1 || wa != 1 || rc != 0) begin
      miscompares++;
      $display("FAIL sw_timing: got lat=%0d wr=%0d wr_at=%0d rd=%0d want lat=2 wr=1 wr_at=1 rd=0", lat, wc, wa, rc);
    end
    do_req(1'b0, F3_W, 32'h10, 32'h0, 1'b0, lat, rd, er, rc, wc, wa);
    vectors++;
    if (rd !== 32'hBEEF_55A1) begin
      miscompares++;
      $display("FAIL sh_readback: got %h want beef55a1", rd);
    end
    do_req(1'b0, F3_W, 32'h14, 32'h0, 1'b1, lat, rd, er, rc, wc, wa);
    vectors++;
    if (rd !== 32'hDEAD_BEEF || lat != 2) begin
      miscompares++;
      $display("FAIL sw_readback_early_ready: got %h lat=%0d want deadbeef lat=2", rd, lat);
    end
  endtask

  task automatic test_errors();
    logic        wes  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0]  f3s  [5] = '{F3_W, F3_H, F3_W, F3_BU, 3'b011};
    logic [31:0] adrs [5] = '{32'h11, 32'h13, 32'h8000, 32'h10, 32'h10};
    int lat, rc, wc, wa;
    logic [31:0] rd;
    logic er;
    for (int i = 0; i < 5; i++) begin
      do_req(wes[i], f3s[i], adrs[i], 32'hFFFF_FFFF, 1'b0, lat, rd, er, rc, wc, wa);
      vectors++;
      if (er !== 1'b1 || lat != 1 || rc != 0 || wc != 0 || rd !== 32'h0) begin
        miscompares++;
        $display("FAIL err_%0d: got err=%b lat=%0d rd=%0d wr=%0d data=%h want err=1 lat=1 rd=0 wr=0 data=0",
                 i, er, lat, rc, wc, rd);
      end
    end
    vectors++;
    if (mem[4] !== 32'hBEEF_55A1) begin
      miscompares++;
      $display("FAIL err_no_write: got mem4=%h want beef55a1", mem[4]);
    end
  endtask

  task automatic test_stall();
    int lat = 0;
    logic [31:0] rd = '0;
    logic bad = 1'b0;
    @(negedge clk);
    req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h14; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = k; rd = rsp_rdata;
        break;
      end
    end
    vectors++;
    if (lat != 2 || rd !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL stall_first: got lat=%0d data=%h want lat=2 data=deadbeef", lat, rd);
    end
    req_we = 1'b1; req_funct3 = F3_W; req_addr = 32'h10; req_wdata = 32'h0; req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF || req_ready !== 1'b0 || mem_write_en !== 1'b0)
        bad = 1'b1;
    end
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL stall_hold: got v=%b data=%h rdy=%b we=%b want v=1 data=deadbeef rdy=0 we=0",
               rsp_valid, rsp_rdata, req_ready, mem_write_en);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (mem[4] !== 32'hBEEF_55A1 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_no_accept: got mem4=%h v=%b rdy=%b want beef55a1 v=0 rdy=1", mem[4], rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset_abort();
    int lat, rc, wc, wa;
    logic [31:0] rd;
    logic er;
    @(negedge clk);
    req_we = 1'b1; req_funct3 = F3_W; req_addr = 32'h20; req_wdata = 32'h1234_5678; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (mem_write_en !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_in_write: got we=%b want 1", mem_write_en);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({req_ready, rsp_valid, rsp_err, mem_read_en, mem_write_en} !== 5'b0 ||
        rsp_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_write_data !== 32'h0) begin
      miscompares++;
      $display("FAIL abort_outputs: got rdy=%b v=%b e=%b re=%b we=%b a=%h wd=%h want all zero",
               req_ready, rsp_valid, rsp_err, mem_read_en, mem_write_en, mem_addr, mem_write_data);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (mem[8] !== 32'hA5A5_0008 || rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_no_commit: got mem8=%h v=%b want a5a50008 v=0", mem[8], rsp_valid);
    end
    do_req(1'b1, F3_W, 32'h20, 32'h1234_5678, 1'b0, lat, rd, er, rc, wc, wa);
    do_req(1'b0, F3_H, 32'h22, 32'h0, 1'b0, lat, rd, er, rc, wc, wa);
    vectors++;
    if (rd !== 32'h0000_1234 || lat != 2 || er !== 1'b0) begin
      miscompares++;
      $display("FAIL after_abort: got %h lat=%0d err=%b want 00001234 lat=2 err=0", rd, lat, er);
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_errors();
    test_stall();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
